// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its PLL/consumer side.
// The master drives lock/restart; the slave (sequencer) drives PLL controls and status.
interface pll_lock_sequencer_if;
  logic       pll_lock;
  logic       restart;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       clk_en;
  logic       fault;
  logic [2:0] state;
  logic [7:0] loss_count;

  modport master (
    output pll_lock, restart,
    input  pll_resetb, pll_bypass, clk_en, fault, state, loss_count
  );

  modport slave (
    input  pll_lock, restart,
    output pll_resetb, pll_bypass, clk_en, fault, state, loss_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Sequences an iCE40 PLL from the reference clock: reset, wait for lock, qualify, run, retry, fault.
// Optional macro PLL_SEQ_BYPASS_FALLBACK_EN: FAULT keeps downstream alive on the bypassed reference.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  pll_lock_sequencer_if.slave  bus
);

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0]  LOSS_SAT    = {LOSS_W{1'b1}};

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [LOSS_W-1:0]    loss_q, loss_d;
  logic                 lock_meta_q, lock_s_q;
  logic                 pll_resetb_q, pll_resetb_d;
  logic                 pll_bypass_q, pll_bypass_d;
  logic                 clk_en_q, clk_en_d;
  logic                 fault_q, fault_d;
  logic                 lock_lost_c;
  logic [LOSS_W-1:0]    loss_inc_c;

  // Two-flop synchronizer for the asynchronous PLL LOCK.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= bus.pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  // State, timer, retry, loss counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_RST;
      timer_q      <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      pll_resetb_q <= 1'b0;
      pll_bypass_q <= 1'b0;
      clk_en_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_resetb_q <= pll_resetb_d;
      pll_bypass_q <= pll_bypass_d;
      clk_en_q     <= clk_en_d;
      fault_q      <= fault_d;
    end
  end

  assign lock_lost_c = (state_q == ST_RUN) && !lock_s_q;
  assign loss_inc_c  = (loss_q == LOSS_SAT) ? loss_q : loss_q + LOSS_W'(1);

  // Next-state logic; restart overrides every other transition but still books a lock loss.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (bus.restart) begin
      state_d = ST_RST;
      timer_d = '0;
      retry_d = '0;
      if (lock_lost_c) loss_d = loss_inc_c;
    end else begin
      case (state_q)
        ST_RST: begin
          if (timer_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = ST_STABLE;
            timer_d = '0;
          end else if (timer_q == LOCK_LAST) begin
            timer_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_RST;
              retry_d = retry_q + RETRY_W'(1);
            end
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // Lock chatter falls back without charging a retry.
          if (!lock_s_q) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_RUN;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_d = ST_RST;
            timer_d = '0;
            loss_d  = loss_inc_c;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RST;
          timer_d = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so outputs change on the same edge as the state.
  always_comb begin
    pll_resetb_d = 1'b0;
    pll_bypass_d = 1'b0;
    clk_en_d     = 1'b0;
    fault_d      = 1'b0;
    case (state_d)
      ST_WAIT_LOCK, ST_STABLE: pll_resetb_d = 1'b1;
      ST_RUN: begin
        pll_resetb_d = 1'b1;
        clk_en_d     = 1'b1;
      end
      ST_FAULT: begin
        fault_d = 1'b1;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
        pll_resetb_d = 1'b1;
        pll_bypass_d = 1'b1;
        clk_en_d     = 1'b1;
`endif
      end
      default: pll_resetb_d = 1'b0;
    endcase
  end

  assign bus.pll_resetb = pll_resetb_q;
  assign bus.pll_bypass = pll_bypass_q;
  assign bus.clk_en     = clk_en_q;
  assign bus.fault      = fault_q;
  assign bus.state      = state_q;
  assign bus.loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: default-parameter instance for sequencing/fault,
// small-parameter instance for fast loss-counter saturation.
module tb_pll_lock_sequencer;

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
  localparam logic FB = 1'b1;
`else
  localparam logic FB = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  pll_lock_sequencer_if bus1 ();
  pll_lock_sequencer_if bus2 ();

  pll_lock_sequencer dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1.slave)
  );

  pll_lock_sequencer #(
    .RST_CYCLES   (2),
    .LOCK_TIMEOUT (8),
    .STABLE_CYCLES(2),
    .MAX_RETRIES  (1),
    .CNT_W        (4)
  ) dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] st_of(input int inst);
    return (inst == 0) ? bus1.state : bus2.state;
  endfunction

  // Bounded wait for a state; an expired budget shows up as a failed state comparison.
  task automatic wait_st(input int inst, input logic [2:0] st, input int budget, input string tag);
    int n;
    n = 0;
    while (st_of(inst) !== st && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(st_of(inst)), 32'(st));
  endtask

  initial begin
    int windows, run_len, bad_len, bad_state, n;
    bit seen_wait, seen_stable;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus1.pll_lock = 1'b0;
    bus1.restart  = 1'b0;
    bus2.pll_lock = 1'b0;
    bus2.restart  = 1'b0;

    // Reset values
    #22;
    chk("rst_state", 32'(bus1.state), 32'(S_RST));
    chk("rst_resetb", 32'(bus1.pll_resetb), 32'd0);
    chk("rst_clk_en", 32'(bus1.clk_en), 32'd0);
    chk("rst_fault", 32'(bus1.fault), 32'd0);
    chk("rst_bypass", 32'(bus1.pll_bypass), 32'd0);
    chk("rst_loss", 32'(bus1.loss_count), 32'd0);
    resetn = 1'b1;

    // Test 1: nominal bring-up, lock 100 cycles after pll_resetb rises
    repeat (15) tick();
    chk("t1_resetb_low_e15", 32'(bus1.pll_resetb), 32'd0);
    chk("t1_state_rst_e15", 32'(bus1.state), 32'(S_RST));
    tick();
    chk("t1_resetb_high_e16", 32'(bus1.pll_resetb), 32'd1);
    chk("t1_state_wait_e16", 32'(bus1.state), 32'(S_WAIT));
    repeat (100) tick();
    bus1.pll_lock = 1'b1;
    repeat (258) tick();
    chk("t1_state_stable_e374", 32'(bus1.state), 32'(S_STABLE));
    chk("t1_clk_en_e374", 32'(bus1.clk_en), 32'd0);
    tick();
    chk("t1_state_run_e375", 32'(bus1.state), 32'(S_RUN));
    chk("t1_clk_en_e375", 32'(bus1.clk_en), 32'd1);
    chk("t1_loss", 32'(bus1.loss_count), 32'd0);

    // Test 2: 5-cycle lock drop in RUN
    bus1.pll_lock = 1'b0;
    repeat (2) tick();
    chk("t2_still_run", 32'(bus1.state), 32'(S_RUN));
    tick();
    chk("t2_clk_en_drop", 32'(bus1.clk_en), 32'd0);
    chk("t2_state_rst", 32'(bus1.state), 32'(S_RST));
    chk("t2_loss_1", 32'(bus1.loss_count), 32'd1);
    repeat (2) tick();
    bus1.pll_lock = 1'b1;
    wait_st(0, S_RUN, 400, "t2_rerun");
    chk("t2_loss_held", 32'(bus1.loss_count), 32'd1);
    chk("t2_clk_en_again", 32'(bus1.clk_en), 32'd1);

    // Test 4: lock toggling every 50 cycles never reaches RUN nor FAULT
    bus1.restart = 1'b1;
    tick();
    bus1.restart = 1'b0;
    chk("t4_restart_rst", 32'(bus1.state), 32'(S_RST));
    bad_state = 0;
    seen_wait = 1'b0;
    seen_stable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus1.pll_lock = i[0];
      for (int c = 0; c < 50; c++) begin
        tick();
        if (bus1.state == S_RUN || bus1.state == S_FAULT) bad_state++;
        if (bus1.state == S_WAIT) seen_wait = 1'b1;
        if (bus1.state == S_STABLE) seen_stable = 1'b1;
      end
    end
    chk("t4_no_run_fault", 32'(bad_state), 32'd0);
    chk("t4_seen_wait", 32'(seen_wait), 32'd1);
    chk("t4_seen_stable", 32'(seen_stable), 32'd1);
    chk("t4_retry_zero", 32'(dut1.retry_q), 32'd0);
    chk("t4_fault_low", 32'(bus1.fault), 32'd0);

    // Test 5a: restart in the same cycle lock loss is seen in RUN
    bus1.pll_lock = 1'b1;
    wait_st(0, S_RUN, 400, "t5_run");
    bus1.pll_lock = 1'b0;
    repeat (2) tick();
    chk("t5_run_before_restart", 32'(bus1.state), 32'(S_RUN));
    bus1.restart = 1'b1;
    tick();
    bus1.restart = 1'b0;
    chk("t5_run_restart_rst", 32'(bus1.state), 32'(S_RST));
    chk("t5_run_restart_loss", 32'(bus1.loss_count), 32'd2);
    chk("t5_run_restart_clk_en", 32'(bus1.clk_en), 32'd0);
    chk("t5_run_restart_retry", 32'(dut1.retry_q), 32'd0);

    // Test 3: lock never asserts -> four 4096-cycle windows then FAULT
    windows = 0;
    run_len = 0;
    bad_len = 0;
    n = 0;
    while (bus1.state !== S_FAULT && n < 20000) begin
      tick();
      n++;
      if (bus1.pll_resetb === 1'b1 && bus1.state === S_WAIT) begin
        run_len++;
      end else if (run_len != 0) begin
        windows++;
        if (run_len != 4096) bad_len++;
        run_len = 0;
      end
    end
    chk("t3_windows", 32'(windows), 32'd4);
    chk("t3_window_len", 32'(bad_len), 32'd0);
    chk("t3_state_fault", 32'(bus1.state), 32'(S_FAULT));
    chk("t3_fault", 32'(bus1.fault), 32'd1);
    chk("t3_clk_en", 32'(bus1.clk_en), 32'(FB));
    chk("t3_bypass", 32'(bus1.pll_bypass), 32'(FB));
    chk("t3_resetb", 32'(bus1.pll_resetb), 32'(FB));
    repeat (20) tick();
    chk("t3_fault_sticky", 32'(bus1.state), 32'(S_FAULT));

    // Test 5b: restart out of FAULT
    bus1.restart = 1'b1;
    tick();
    bus1.restart = 1'b0;
    chk("t5_fault_restart_rst", 32'(bus1.state), 32'(S_RST));
    chk("t5_fault_cleared", 32'(bus1.fault), 32'd0);
    chk("t5_bypass_cleared", 32'(bus1.pll_bypass), 32'd0);
    chk("t5_fault_restart_retry", 32'(dut1.retry_q), 32'd0);
    chk("t5_loss_preserved", 32'(bus1.loss_count), 32'd2);

    // Test 6a: asynchronous reset mid-STABLE
    bus1.pll_lock = 1'b1;
    wait_st(0, S_STABLE, 100, "t6_stable");
    repeat (5) tick();
    #3;
    resetn = 1'b0;
    #1;
    chk("t6_async_state", 32'(bus1.state), 32'(S_RST));
    chk("t6_async_resetb", 32'(bus1.pll_resetb), 32'd0);
    chk("t6_async_clk_en", 32'(bus1.clk_en), 32'd0);
    chk("t6_async_fault", 32'(bus1.fault), 32'd0);
    chk("t6_async_loss", 32'(bus1.loss_count), 32'd0);
    chk("t6_async_sync", 32'(dut1.lock_s_q), 32'd0);
    #2;
    resetn = 1'b1;

    // Small instance: lock held low -> FAULT after two short windows
    repeat (40) tick();
    chk("s_fault", 32'(bus2.fault), 32'd1);
    bus2.restart = 1'b1;
    tick();
    bus2.restart = 1'b0;
    chk("s_restart", 32'(bus2.state), 32'(S_RST));

    // Test 6b: 300 lock losses saturate loss_count at 255
    for (int i = 0; i < 300; i++) begin
      bus2.pll_lock = 1'b1;
      wait_st(1, S_RUN, 50, "s_run");
      bus2.pll_lock = 1'b0;
      wait_st(1, S_RST, 10, "s_loss_rst");
      if (i == 0) chk("s_loss_1", 32'(bus2.loss_count), 32'd1);
      if (i == 253) chk("s_loss_254", 32'(bus2.loss_count), 32'd254);
      if (i == 254) chk("s_loss_255", 32'(bus2.loss_count), 32'd255);
    end
    chk("s_loss_sat", 32'(bus2.loss_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
